pwm_mixer: RTL and testbench
============================

PWM_MIXER -- requirements
Module: pwm_mixer

Interface
REQ-001 SHALL have parameter ENV_PRESCALE, default 64, meaning the number of PWM periods per envelope step (legal range 1..1024).
REQ-002 SHALL have port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have ports sample1..sample4, input, 7 bits each: unsigned voice waveform samples from the sample generator.
REQ-005 SHALL have port gate, input, 4 bits: per-voice note gate; bit n-1 controls voice n.
REQ-006 SHALL have port sustain_level, input, 4 bits: common sustain level for all envelopes.
REQ-007 SHALL have port pwm_out, output, 1 bit: audio PWM output.
REQ-008 SHALL have port mix_q, output, 9 bits: mix value latched for the current PWM period.
REQ-009 SHALL have port env_levels, output, 16 bits: envelope levels packed as {L4,L3,L2,L1}, 4 bits each.
REQ-010 SHALL have port active, output, 4 bits: bit n-1 high when voice n envelope state is not IDLE.
REQ-011 SHALL have port period_start, output, 1 bit: one-cycle pulse in the first cycle of each PWM period.

Function
REQ-012 SHALL keep pwm_cnt, a 9-bit free-running counter that increments every cycle and wraps 511->0; the PWM period is 512 cycles.
REQ-013 SHALL drive period_start high exactly when pwm_cnt==0.
REQ-014 SHALL compute scaled_n = (sample_n * L_n) >> 4 per voice; 11-bit product, 7-bit result, max 119.
REQ-015 SHALL compute mix = scaled_1+scaled_2+scaled_3+scaled_4 in 9 bits, max 476; no saturation logic needed.
REQ-016 SHALL load mix_q <= mix in the cycle where pwm_cnt==511 and hold mix_q constant for the rest of the period.
REQ-017 SHALL derive pwm_out combinationally as (pwm_cnt < mix_q): high for exactly mix_q cycles at the start of each period.
REQ-018 SHALL keep a period prescaler that advances when pwm_cnt==511; env_tick is a one-cycle pulse at pwm_cnt==511 when the prescaler equals ENV_PRESCALE-1, and the prescaler then wraps to 0.
REQ-019 SHALL implement per voice a state machine with states IDLE, ATTACK, DECAY, SUSTAIN, RELEASE and a 4-bit level.
REQ-020 SHALL transition on gate alone, next cycle, regardless of env_tick: gate=1 in IDLE or RELEASE -> ATTACK with level kept; gate=0 in ATTACK, DECAY or SUSTAIN -> RELEASE with level kept.
REQ-021 SHALL apply on env_tick, only when no gate transition fires that cycle:
- ATTACK: level<15 -> level+1; level==15 -> DECAY.
- DECAY: level>sustain_level -> level-1; otherwise -> SUSTAIN.
- SUSTAIN: hold level.
- RELEASE: level>0 -> level-1; level==0 -> IDLE.
- IDLE: level stays 0.
REQ-022 SHALL give a gate transition priority over env_tick in the same cycle; level is unchanged that cycle.
REQ-023 SHALL NOT move level in SUSTAIN when sustain_level changes; level holds until gate falls.
REQ-024 SHALL never wrap level: level never exceeds 15 and never goes below 0.
REQ-025 SHALL handle voices independently; all voices share env_tick.

Reset
REQ-026 SHALL, while rst_n==0 at a clock edge, set pwm_cnt=0, prescaler=0, mix_q=0, every state=IDLE and every level=0.
REQ-027 SHALL hold these reset output values: pwm_out=0, env_levels=0, active=0, period_start=1 (pwm_cnt==0).
REQ-028 SHALL, on reset asserted mid-note or mid-period, apply REQ-026 immediately; the first full period after release starts at pwm_cnt=0.

Verification
REQ-029 SHALL cover idle: reset, gate=0, random samples -> mix_q=0, pwm_out constantly 0, active=0.
REQ-030 SHALL cover attack/decay: ENV_PRESCALE=1, gate[0]=1, sustain_level=8 -> L1 rises 1 per 512 cycles to 15 (15 ticks), DECAY on 16th tick, reaches 8 after 7 more ticks, SUSTAIN next tick; active=0001.
REQ-031 SHALL cover full mix: all voices at L=15, all samples=127 -> mix_q=476 after the next wrap; pwm_out high 476 of 512 cycles per period, period_start every 512 cycles.
REQ-032 SHALL cover release: gate[1] falls at L2=5 in ATTACK -> RELEASE next cycle, 5 ticks to 0, IDLE on next tick, active[1] clears.
REQ-033 SHALL cover priority: gate[2] rises in the env_tick cycle while IDLE -> state ATTACK, L3 stays 0 until the following tick.
REQ-034 SHALL cover mid-run reset: rst_n low for 1 cycle with pwm_cnt=300 and voices in SUSTAIN -> all outputs at reset values next cycle, then pwm_cnt counts from 0.

Source files
------------

// File: rtl/pwm_mixer.sv
// Four-voice envelope mixer driving a 512-cycle PWM audio output.
// Each voice runs its own ADSR envelope, all stepped by a shared tick.
module pwm_mixer #(
    parameter int ENV_PRESCALE = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  sample1,
    input  logic [6:0]  sample2,
    input  logic [6:0]  sample3,
    input  logic [6:0]  sample4,
    input  logic [3:0]  gate,
    input  logic [3:0]  sustain_level,
    output logic        pwm_out,
    output logic [8:0]  mix_q,
    output logic [15:0] env_levels,
    output logic [3:0]  active,
    output logic        period_start
);

    localparam int PW = (ENV_PRESCALE > 1) ? $clog2(ENV_PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(ENV_PRESCALE - 1);

    typedef enum logic [2:0] {
        IDLE,
        ATTACK,
        DECAY,
        SUSTAIN,
        RELEASE
    } env_state_t;

    logic [8:0]    pwm_cnt;
    logic [PW-1:0] presc;
    logic          period_end;
    logic          env_tick;
    logic [8:0]    mix;
    logic [6:0]    samples [4];
    logic [10:0]   prod    [4];
    env_state_t    state_q [4];
    env_state_t    state_d [4];
    logic [3:0]    level_q [4];
    logic [3:0]    level_d [4];

    assign period_end = (pwm_cnt == 9'd511);
    assign env_tick   = period_end && (presc == PRE_LAST);

    always_comb begin
        samples[0] = sample1;
        samples[1] = sample2;
        samples[2] = sample3;
        samples[3] = sample4;
        mix = '0;
        for (int n = 0; n < 4; n++) begin
            prod[n] = 11'(samples[n]) * 11'(level_q[n]);
            mix     = mix + {2'b00, prod[n][10:4]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            presc   <= '0;
            mix_q   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 9'd1;
            if (period_end) begin
                mix_q <= mix;
                presc <= env_tick ? '0 : presc + PW'(1);
            end
        end
    end

    // Gate edges win over the envelope tick and leave the level untouched.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            state_d[n] = state_q[n];
            level_d[n] = level_q[n];
            if (gate[n] && (state_q[n] == IDLE || state_q[n] == RELEASE)) begin
                state_d[n] = ATTACK;
            end else if (!gate[n] && (state_q[n] == ATTACK ||
                                      state_q[n] == DECAY ||
                                      state_q[n] == SUSTAIN)) begin
                state_d[n] = RELEASE;
            end else if (env_tick) begin
                case (state_q[n])
                    ATTACK: begin
                        if (level_q[n] != 4'd15) level_d[n] = level_q[n] + 4'd1;
                        else                     state_d[n] = DECAY;
                    end
                    DECAY: begin
                        if (level_q[n] > sustain_level) level_d[n] = level_q[n] - 4'd1;
                        else                            state_d[n] = SUSTAIN;
                    end
                    RELEASE: begin
                        if (level_q[n] != 4'd0) level_d[n] = level_q[n] - 4'd1;
                        else                    state_d[n] = IDLE;
                    end
                    default: begin
                        state_d[n] = state_q[n];
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (!rst_n) begin
                state_q[n] <= IDLE;
                level_q[n] <= '0;
            end else begin
                state_q[n] <= state_d[n];
                level_q[n] <= level_d[n];
            end
        end
    end

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            env_levels[4*n +: 4] = level_q[n];
            active[n]            = (state_q[n] != IDLE);
        end
    end

    assign pwm_out      = (pwm_cnt < mix_q);
    assign period_start = (pwm_cnt == 9'd0);

endmodule

// File: tb/tb_pwm_mixer.sv
// Bench for pwm_mixer: scripted envelope scenarios plus random stimulus,
// every cycle checked against a cycle-level behavioural model.
module tb_pwm_mixer;

    logic        clk;
    logic        rst_n;
    logic [6:0]  smp [4];
    logic [3:0]  gate;
    logic [3:0]  sus;

    logic        pwm_a, pwm_b;
    logic [8:0]  mixq_a, mixq_b;
    logic [15:0] env_a, env_b;
    logic [3:0]  act_a, act_b;
    logic        ps_a, ps_b;

    pwm_mixer #(.ENV_PRESCALE(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .sample1(smp[0]), .sample2(smp[1]), .sample3(smp[2]), .sample4(smp[3]),
        .gate(gate), .sustain_level(sus),
        .pwm_out(pwm_a), .mix_q(mixq_a), .env_levels(env_a),
        .active(act_a), .period_start(ps_a)
    );

    pwm_mixer #(.ENV_PRESCALE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .sample1(smp[0]), .sample2(smp[1]), .sample3(smp[2]), .sample4(smp[3]),
        .gate(gate), .sustain_level(sus),
        .pwm_out(pwm_b), .mix_q(mixq_b), .env_levels(env_b),
        .active(act_b), .period_start(ps_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    bit rand_smp = 1'b1;

    // Model state: index 0 mirrors u_dut (prescale 1), index 1 u_dut3.
    // Envelope phases: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release.
    int m_cnt   [2];
    int m_presc [2];
    int m_mixq  [2];
    int m_st    [2][4];
    int m_lv    [2][4];

    function automatic int pre(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                      name, act, act, exp, exp);
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_cnt[k] = 0; m_presc[k] = 0; m_mixq[k] = 0;
                for (int v = 0; v < 4; v++) begin
                    m_st[k][v] = 0; m_lv[k][v] = 0;
                end
            end else begin
                bit tick;
                int mix;
                tick = (m_cnt[k] == 511) && (m_presc[k] == pre(k) - 1);
                mix = 0;
                for (int v = 0; v < 4; v++) mix += (int'(smp[v]) * m_lv[k][v]) / 16;
                if (m_cnt[k] == 511) begin
                    m_mixq[k]  = mix;
                    m_presc[k] = (m_presc[k] + 1) % pre(k);
                end
                for (int v = 0; v < 4; v++) begin
                    int s, l;
                    s = m_st[k][v]; l = m_lv[k][v];
                    if (gate[v] && (s == 0 || s == 4)) s = 1;
                    else if (!gate[v] && (s >= 1 && s <= 3)) s = 4;
                    else if (tick) begin
                        if (s == 1) begin
                            if (l < 15) l++; else s = 2;
                        end else if (s == 2) begin
                            if (l > int'(sus)) l--; else s = 3;
                        end else if (s == 4) begin
                            if (l > 0) l--; else s = 0;
                        end
                    end
                    m_st[k][v] = s; m_lv[k][v] = l;
                end
                m_cnt[k] = (m_cnt[k] + 1) % 512;
            end
        end
    endtask

    task automatic model_check();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] exp, act;
            logic [15:0] e_env;
            logic [3:0]  e_act;
            e_env = '0; e_act = '0;
            for (int v = 0; v < 4; v++) begin
                e_env[4*v +: 4] = 4'(m_lv[k][v]);
                e_act[v]        = (m_st[k][v] != 0);
            end
            exp = {1'b0, (m_cnt[k] < m_mixq[k]), 9'(m_mixq[k]), e_env, e_act,
                   (m_cnt[k] == 0)};
            if (k == 0) begin
                act = {1'b0, pwm_a, mixq_a, env_a, act_a, ps_a};
                chk("model_p1", act, exp);
            end else begin
                act = {1'b0, pwm_b, mixq_b, env_b, act_b, ps_b};
                chk("model_p3", act, exp);
            end
        end
    endtask

    task automatic cyc();
        if (rand_smp)
            for (int v = 0; v < 4; v++) smp[v] = 7'($urandom_range(0, 127));
        model_update();
        @(posedge clk);
        #1;
        model_check();
    endtask

    task automatic run_to_cnt(int target);
        int n;
        n = 0;
        while (m_cnt[0] != target && n < 600) begin
            cyc();
            n++;
        end
        if (m_cnt[0] != target) chk("run_to_cnt_timeout", 32'(m_cnt[0]), 32'(target));
    endtask

    task automatic run_ticks(int n);
        for (int i = 0; i < n; i++) begin
            run_to_cnt(511);
            cyc();
        end
    endtask

    typedef struct {
        int         ticks;
        logic [3:0] sus;
        logic [3:0] exp_l1;
        logic [3:0] exp_act;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int done;
        int hi;
        int ps_cnt;

        tbl[0] = '{1,  4'd8, 4'd1,  4'b0001};
        tbl[1] = '{5,  4'd8, 4'd5,  4'b0001};
        tbl[2] = '{14, 4'd8, 4'd14, 4'b0001};
        tbl[3] = '{15, 4'd8, 4'd15, 4'b0001};
        tbl[4] = '{16, 4'd8, 4'd15, 4'b0001};
        tbl[5] = '{17, 4'd8, 4'd14, 4'b0001};
        tbl[6] = '{23, 4'd8, 4'd8,  4'b0001};
        tbl[7] = '{24, 4'd8, 4'd8,  4'b0001};
        tbl[8] = '{26, 4'd3, 4'd8,  4'b0001};

        rst_n = 1'b0;
        gate  = 4'b0000;
        sus   = 4'd8;
        for (int v = 0; v < 4; v++) smp[v] = 7'($urandom_range(0, 127));

        cyc();
        cyc();
        chk("rst_pwm_out", 32'(pwm_a), 0);
        chk("rst_mix_q", 32'(mixq_a), 0);
        chk("rst_env_levels", 32'(env_a), 0);
        chk("rst_active", 32'(act_a), 0);
        chk("rst_period_start", 32'(ps_a), 1);
        rst_n = 1'b1;

        hi = 0;
        for (int i = 0; i < 1100; i++) begin
            cyc();
            if (pwm_a) hi++;
        end
        chk("idle_pwm_high_cycles", 32'(hi), 0);
        chk("idle_mix_q", 32'(mixq_a), 0);
        chk("idle_active", 32'(act_a), 0);

        run_to_cnt(0);
        gate = 4'b0001;
        cyc();
        chk("attack_start_l1", 32'(env_a[3:0]), 0);
        done = 0;
        for (int i = 0; i < 9; i++) begin
            sus = tbl[i].sus;
            run_ticks(tbl[i].ticks - done);
            done = tbl[i].ticks;
            chk($sformatf("adsr_l1_tick%0d", tbl[i].ticks),
                32'(env_a[3:0]), 32'(tbl[i].exp_l1));
            chk($sformatf("adsr_active_tick%0d", tbl[i].ticks),
                32'(act_a), 32'(tbl[i].exp_act));
        end

        gate = 4'b0011;
        cyc();
        run_ticks(5);
        chk("rel_l2_before", 32'(env_a[7:4]), 5);
        gate = 4'b0001;
        cyc();
        chk("rel_l2_held", 32'(env_a[7:4]), 5);
        chk("rel_active_held", 32'(act_a), 32'(4'b0011));
        run_ticks(5);
        chk("rel_l2_zero", 32'(env_a[7:4]), 0);
        chk("rel_active_zero", 32'(act_a), 32'(4'b0011));
        run_ticks(1);
        chk("rel_active_idle", 32'(act_a), 32'(4'b0001));
        chk("rel_env_levels", 32'(env_a), 32'(16'h0008));

        run_to_cnt(511);
        gate = 4'b0101;
        cyc();
        chk("prio_l3", 32'(env_a[11:8]), 0);
        chk("prio_active", 32'(act_a), 32'(4'b0101));
        run_to_cnt(511);
        chk("prio_l3_pre_tick", 32'(env_a[11:8]), 0);
        cyc();
        chk("prio_l3_post_tick", 32'(env_a[11:8]), 1);

        sus  = 4'd15;
        gate = 4'b0000;
        cyc();
        gate = 4'b1111;
        rand_smp = 1'b0;
        for (int v = 0; v < 4; v++) smp[v] = 7'd127;
        run_ticks(17);
        chk("full_env_levels", 32'(env_a), 32'(16'hFFFF));
        chk("full_active", 32'(act_a), 32'(4'hF));
        chk("full_mix_q", 32'(mixq_a), 476);
        hi = 0;
        ps_cnt = 0;
        for (int i = 0; i < 1024; i++) begin
            cyc();
            if (i < 512 && pwm_a) hi++;
            if (ps_a) ps_cnt++;
        end
        chk("full_pwm_high_cycles", 32'(hi), 476);
        chk("full_period_starts", 32'(ps_cnt), 2);

        run_to_cnt(300);
        rst_n = 1'b0;
        cyc();
        chk("midrst_pwm_out", 32'(pwm_a), 0);
        chk("midrst_mix_q", 32'(mixq_a), 0);
        chk("midrst_env_levels", 32'(env_a), 0);
        chk("midrst_active", 32'(act_a), 0);
        chk("midrst_period_start", 32'(ps_a), 1);
        rst_n = 1'b1;
        cyc();
        chk("midrst_ps_after", 32'(ps_a), 0);
        chk("midrst_reattack", 32'(act_a), 32'(4'hF));
        for (int i = 0; i < 511; i++) cyc();
        chk("midrst_next_period", 32'(ps_a), 1);

        rand_smp = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 149) == 0)
                gate[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 499) == 0)
                sus = 4'($urandom_range(0, 15));
            cyc();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
